// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM encoding, select width and the
// response record handed back to the command side.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int NSLV_DEF   = 4;
  localparam int DWIDTH_DEF = 8;
  localparam int SELW       = $clog2(NSLV_DEF);

  typedef struct packed {
    logic [DWIDTH_DEF-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

  // A single slave still needs a 1-bit select index to keep vectors legal.
  function automatic int sel_width(input int nslv);
    return (nslv > 1) ? $clog2(nslv) : 1;
  endfunction

endpackage

// File: rtl/apb_sel_decode.sv
// Slave index to one-hot PSEL, plus the return-path mux that picks the
// addressed slave's PRDATA, PREADY and PSLVERR. Purely combinational.
module apb_sel_decode
  import apb_pkg::*;
#(
  parameter int NSLV   = 4,
  parameter int DWIDTH = 8,
  parameter int SW     = sel_width(NSLV)
) (
  input  logic [SW-1:0]          sel_i,
  input  logic [NSLV*DWIDTH-1:0] prdata_i,
  input  logic [NSLV-1:0]        pready_i,
  input  logic [NSLV-1:0]        pslverr_i,
  output logic [NSLV-1:0]        psel_oh_o,
  output logic [DWIDTH-1:0]      rdata_o,
  output logic                   ready_o,
  output logic                   slverr_o
);

  for (genvar i = 0; i < NSLV; i++) begin : g_oh
    assign psel_oh_o[i] = (sel_i == SW'(i));
  end

  assign rdata_o  = prdata_i[sel_i*DWIDTH +: DWIDTH];
  assign ready_o  = pready_i[sel_i];
  assign slverr_o = pslverr_i[sel_i];

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command port to APB3 master. One transfer in flight; each
// transfer ends with a single-cycle response strobe carrying data and error.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 8,
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [AWIDTH-1:0]      cmd_addr,
  input  logic [DWIDTH-1:0]      cmd_wdata,
  output logic                   rsp_valid,
  output logic [DWIDTH-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [NSLV-1:0]        PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [AWIDTH-1:0]      PADDR,
  output logic [DWIDTH-1:0]      PWDATA,
  input  logic [NSLV*DWIDTH-1:0] PRDATA,
  input  logic [NSLV-1:0]        PREADY,
  input  logic [NSLV-1:0]        PSLVERR
);

  localparam int                SW      = sel_width(NSLV);
  localparam int                CNTW    = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0]   CNT_MAX = CNTW'(TIMEOUT);

  apb_state_e        state_q;
  logic              cmd_ready_q;
  logic [NSLV-1:0]   psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [AWIDTH-1:0] paddr_q;
  logic [DWIDTH-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DWIDTH-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic [CNTW-1:0]   cnt_q;
  logic [CNTW-1:0]   cnt_d;

  logic [SW-1:0]     cmd_sel_s;
  logic [SW-1:0]     xfer_sel_s;
  logic [SW-1:0]     dec_sel_s;
  logic [NSLV-1:0]   sel_oh_s;
  logic [DWIDTH-1:0] sel_rdata_s;
  logic              sel_ready_s;
  logic              sel_err_s;
  logic              timeout_s;

  if (NSLV > 1) begin : g_sel
    assign cmd_sel_s  = cmd_addr[AWIDTH-1 -: SW];
    assign xfer_sel_s = paddr_q[AWIDTH-1 -: SW];
  end else begin : g_sel_single
    assign cmd_sel_s  = '0;
    assign xfer_sel_s = '0;
  end

  // While idle the decoder looks at the incoming command; once a transfer is
  // launched it follows the latched address so the return mux stays put.
  assign dec_sel_s = (state_q == ST_IDLE) ? cmd_sel_s : xfer_sel_s;

  apb_sel_decode #(
    .NSLV   (NSLV),
    .DWIDTH (DWIDTH),
    .SW     (SW)
  ) u_sel_decode (
    .sel_i     (dec_sel_s),
    .prdata_i  (PRDATA),
    .pready_i  (PREADY),
    .pslverr_i (PSLVERR),
    .psel_oh_o (sel_oh_s),
    .rdata_o   (sel_rdata_s),
    .ready_o   (sel_ready_s),
    .slverr_o  (sel_err_s)
  );

  assign cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign timeout_s = (cnt_d == CNT_MAX);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            pwrite_q    <= cmd_write;
            paddr_q     <= cmd_addr;
            pwdata_q    <= cmd_wdata;
            psel_q      <= sel_oh_s;
            state_q     <= ST_SETUP;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          cnt_q <= cnt_d;
          // A slave that answers on the last allowed cycle still wins over the timeout.
          if (sel_ready_s) begin
            rsp_rdata_q <= pwrite_q ? '0 : sel_rdata_s;
            rsp_err_q   <= sel_err_s;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (timeout_s) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            state_q <= ST_ACCESS;
          end
        end
        ST_RESP: begin
          cnt_q       <= '0;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          cnt_q       <= '0;
          cmd_ready_q <= 1'b0;
          psel_q      <= '0;
          penable_q   <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream neighbour of the APB register slaves (e.g. the RW config register): converts a simple valid/ready command interface from the control logic into APB3 transfers.
- Drives PSEL, PENABLE, PWRITE, PADDR and PWDATA, and samples PRDATA, PREADY and PSLVERR.
- Decodes the upper address bits into one-hot select lines for up to NSLV slaves.
- Returns read data and an error flag on a one-cycle response strobe.

Parameters:
- DWIDTH, 8: data width of PWDATA, PRDATA and the command/response data.
- AWIDTH, 8: address width of PADDR and cmd_addr.
- NSLV, 4: number of slaves; must be a power of 2, 1..16. The top log2(NSLV) bits of the address select the slave.
- TIMEOUT, 16: maximum number of ACCESS cycles with PREADY low before the bridge aborts the transfer.

Ports:
- PCLK  in  1  system clock; all logic is on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AWIDTH  target address.
- cmd_wdata  in  DWIDTH  write data.
- rsp_valid  out  1  one-cycle pulse at the end of each transfer.
- rsp_rdata  out  DWIDTH  read data; zero for writes.
- rsp_err  out  1  PSLVERR sampled high, or timeout.
- PSEL  out  NSLV  one-hot slave select.
- PENABLE  out  1  ACCESS phase indicator.
- PWRITE  out  1  transfer direction.
- PADDR  out  AWIDTH  transfer address.
- PWDATA  out  DWIDTH  write data.
- PRDATA  in  NSLV*DWIDTH  read data buses, concatenated; slave i occupies bits [i*DWIDTH +: DWIDTH].
- PREADY  in  NSLV  per-slave ready; tie high for slaves without wait states.
- PSLVERR  in  NSLV  per-slave error; tie low if unused.

Behaviour:
- Reset (PRESET high at a PCLK edge): state=IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0; cmd_ready=0; rsp_valid=0, rsp_rdata=0, rsp_err=0; timeout counter=0.
- Reset asserted mid-transfer aborts the transfer immediately. No rsp_valid is generated for the aborted command.
- The FSM has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA.
  - Set PSEL[sel]=1, where sel = cmd_addr[AWIDTH-1 -: log2(NSLV)], then go to SETUP.
  - When NSLV=1, sel=0.
- SETUP (exactly 1 cycle): PSEL held, PENABLE=0, cmd_ready=0. Next state is ACCESS.
- ACCESS:
  - PENABLE=1 and the counter increments each cycle.
  - If PREADY[sel]=1: capture PRDATA[sel] (reads only; writes capture 0) and PSLVERR[sel] into the response registers. Drop PSEL and PENABLE, go to RESP.
  - If the counter reaches TIMEOUT with PREADY[sel] still low: drop PSEL and PENABLE, set rsp_rdata=0 and rsp_err=1, go to RESP.
  - PADDR, PWRITE and PWDATA are stable throughout SETUP and ACCESS.
- RESP (1 cycle): rsp_valid=1 with rsp_rdata and rsp_err valid. Next state is IDLE, and the counter clears.
- Latency:
  - Zero-wait transfer: command accepted at edge N; SETUP in cycle N+1; ACCESS in cycle N+2; rsp_valid high in cycle N+3.
  - Each wait state adds 1 cycle.
  - Minimum command-to-command spacing is 4 cycles; cmd_ready is low outside IDLE.
- PSEL is never multi-hot. PENABLE is never high without PSEL.
- rsp_rdata/rsp_err hold their value after rsp_valid until the next response.
- The counter width is clog2(TIMEOUT+1). The counter saturates and never wraps.
- The bridge does not retry after an error.

Decomposition:
- Shared package apb_pkg holds:
  - an FSM state enum (IDLE, SETUP, ACCESS, RESP; 2 bits);
  - the localparam SELW=clog2(NSLV);
  - a response-struct typedef {rdata, err}.
- One natural sub-module: apb_sel_decode (address to one-hot PSEL, plus the mux for PRDATA, PREADY and PSLVERR). It is purely combinational.

Test Plan:
1. Zero-wait write: cmd_write=1, addr=0x40, wdata=0xA5, NSLV=4, all PREADY=1.
   -> PSEL=4'b0010 for 2 cycles; PENABLE high 1 cycle; PWDATA=0xA5; rsp_valid at N+3 with err=0, rdata=0.
2. Read with 3 wait states: slave 3 holds PREADY low for 3 ACCESS cycles, PRDATA=0x5C.
   -> PENABLE high 4 cycles; rsp_valid at N+6 with rsp_rdata=0x5C.
3. Slave error: write to slave 0 with PSLVERR[0]=1 when PREADY=1.
   -> rsp_err=1 on rsp_valid; next command accepted normally.
4. Timeout: TIMEOUT=16, slave 2 PREADY stuck low.
   -> PSEL and PENABLE drop after 16 ACCESS cycles; rsp_valid with rsp_err=1, rsp_rdata=0; FSM returns to IDLE.
5. Reset mid-ACCESS: assert PRESET during a wait state.
   -> next cycle all APB outputs are 0, rsp_valid never pulses, cmd_ready=1 after reset deasserts.
6. Back-to-back: cmd_valid held high for 3 commands.
   -> exactly 3 transfers, 4-cycle spacing, cmd_ready low outside IDLE, responses in order.
